i2c_write_sequencer: RTL
========================

# i2c_write_sequencer

Round-robin controller that shares one byte-level I2C master engine between `NREQ` requesters. Each request is a single register write: device address + W, register address, data byte. The block sequences the three bytes through the engine, retries on NACK, bounds every byte with a timeout, and returns a per-requester completion status. It sits between system agents (config FSMs, CPU bridge) and the I2C bit engine.

## Interface

Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `MAX_RETRY`, 2: re-attempts of the whole transaction after a NACK (0..7).
- `TIMEOUT_CLKS`, 4096: max cycles from `eng_start` to `eng_done` per byte.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `req_valid` input NREQ: request pending per requester; held until `req_ready`.
- `req_dev` input NREQ*7: 7-bit device address, requester i at `[7i+6:7i]`.
- `req_reg` input NREQ*8: register address, requester i at `[8i+7:8i]`.
- `req_data` input NREQ*8: write data, requester i at `[8i+7:8i]`.
- `req_ready` output NREQ: one-cycle one-hot accept pulse.
- `rsp_done` output NREQ: one-cycle one-hot completion pulse.
- `rsp_err` output 2: status, valid with `rsp_done`. 00 ok, 01 address NACK, 10 reg/data NACK, 11 timeout.
- `busy` output 1: high from accept through response.
- `eng_start` output 1: one-cycle byte command to engine.
- `eng_byte` output 8: byte to send, stable from `eng_start` to `eng_done`.
- `eng_first` output 1: engine issues START before this byte.
- `eng_last` output 1: engine issues STOP after this byte.
- `eng_busy` input 1: engine cannot accept a command.
- `eng_done` input 1: one-cycle pulse, byte and ACK slot finished.
- `eng_nack` input 1: valid with `eng_done`, slave NACKed. The engine always issues STOP on its own after a NACK.

## Operation

- FSM states: IDLE, SEND_DEV, WAIT_DEV, SEND_REG, WAIT_REG, SEND_DAT, WAIT_DAT, RESP.
- IDLE: if any `req_valid`, grant the first set bit searching upward from `last_grant+1` (mod NREQ). Pulse `req_ready[g]`, latch dev/reg/data, clear retry count, then go to SEND_DEV. `last_grant` resets to NREQ-1, so requester 0 wins first.
- SEND_x: wait for `eng_busy`=0, pulse `eng_start` with the byte, then go to WAIT_x. Bytes and flags:
  - SEND_DEV: byte `{dev,1'b0}`, `eng_first`=1.
  - SEND_REG: byte `reg`, no flags.
  - SEND_DAT: byte `data`, `eng_last`=1.
- WAIT_x on `eng_done`:
  - `eng_nack`=0: advance to the next SEND state, or to RESP with status 00 after the data byte.
  - `eng_nack`=1 and retry count < MAX_RETRY: increment the count and return to SEND_DEV.
  - `eng_nack`=1 otherwise: go to RESP with status 01 (from WAIT_DEV) or 10 (from WAIT_REG or WAIT_DAT).
- Timeout: the counter clears at each `eng_start` and increments in WAIT_x. When it reaches TIMEOUT_CLKS-1 without `eng_done`, go to RESP with status 11. Timeouts are not retried. `eng_done` arriving in the same cycle as the timeout wins.
- RESP: pulse `rsp_done[g]` with `rsp_err`, update `last_grant`=g, return to IDLE.
- `req_valid` changes while busy are ignored. Deasserting a request before its grant withdraws it.

## Timing

- Reset values:
  - All outputs 0, `eng_byte`=0.
  - State IDLE, counters 0, `last_grant`=NREQ-1.
- A reset mid-transaction aborts with no `rsp_done`. The engine is reset by the same `reset`.
- Accept latency: `req_ready` rises 1 cycle after `req_valid` is sampled in IDLE.
- `eng_start` is issued 1 cycle after entering SEND_x with `eng_busy`=0.
- The next byte's `eng_start` comes no earlier than 2 cycles after `eng_done`.
- `rsp_done` comes 1 cycle after the final `eng_done` or the timeout.
- The next grant can be issued 1 cycle after `rsp_done`. Minimum gap between transactions: 2 cycles.
- `busy` is high from the `req_ready` cycle through the `rsp_done` cycle.

## Structure

- Package `i2c_pkg`:
  - Error code constants `I2C_OK`, `I2C_NACK_ADDR`, `I2C_NACK_DATA`, `I2C_TIMEOUT`.
  - State enum.
  - `I2C_WRITE`=1'b0 R/W bit constant.
- Sub-module `rr_arbiter` (NREQ requests, `last_grant` input, one-hot grant plus index output, combinational), reused by other shared-bus controllers.
- Timeout counter width: $clog2(TIMEOUT_CLKS).

## Test plan

- Single write, requester 0 (dev 0x50, reg 0x10, data 0xA5), engine model ACKs everything:
  - bytes 0xA0 (first), 0x10, 0xA5 (last);
  - `rsp_done[0]` with err 00.
- Requesters 0 and 1 asserted together for 3 back-to-back requests each: grants alternate 0,1,0,1,0,1, with no requester granted twice in a row while the other is pending.
- Address NACK on the first 2 attempts with MAX_RETRY=2: 3 START+0xA0 sequences, the third completes, err 00. NACK on every attempt gives err 01 after 3 attempts.
- Data-byte NACK on every attempt: full retry from the device byte, final err 10.
- Engine never returns `eng_done` (TIMEOUT_CLKS=16): `rsp_done` 17 cycles after `eng_start`, err 11, `busy` falls.
- `reset` pulsed during WAIT_REG: all outputs 0 next cycle, no `rsp_done`, and the next request is granted starting from requester 0.

Source files
------------

// File: rtl/i2c_write_sequencer_pkg.sv
// i2c_pkg: shared types and constants for the I2C write sequencer.
//   - rsp_err status codes
//   - R/W bit value for a write
//   - sequencer FSM state encoding
//   - latched request record (device, register, data)
package i2c_pkg;

    localparam logic [1:0] I2C_OK        = 2'b00;
    localparam logic [1:0] I2C_NACK_ADDR = 2'b01;
    localparam logic [1:0] I2C_NACK_DATA = 2'b10;
    localparam logic [1:0] I2C_TIMEOUT   = 2'b11;

    localparam logic I2C_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SEND_DEV,
        WAIT_DEV,
        SEND_REG,
        WAIT_REG,
        SEND_DAT,
        WAIT_DAT,
        RESP
    } seq_state_e;

    typedef struct packed {
        logic [6:0] dev;
        logic [7:0] regad;
        logic [7:0] data;
    } wr_req_t;

endpackage

// File: rtl/i2c_write_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req_i          : pending requests
//   last_grant_i   : index granted last time; search starts one above it
//   grant_o        : one-hot winner (all zero when nothing pending)
//   grant_idx_o    : binary index of the winner
//   grant_valid_o  : at least one request was pending
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] grant_idx_o,
    output logic            grant_valid_o
);

    logic            found;
    logic [IDXW-1:0] k;

    // Walk NREQ slots starting at last_grant+1 (wrapping); first hit wins,
    // so the previous winner is checked last.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        k           = '0;
        for (int i = 1; i <= NREQ; i++) begin
            k = IDXW'((int'(last_grant_i) + i) % NREQ);
            if (!found && req_i[k]) begin
                found       = 1'b1;
                grant_o[k]  = 1'b1;
                grant_idx_o = k;
            end
        end
        grant_valid_o = found;
    end

endmodule

// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer: shares one byte-level I2C master engine between NREQ
// requesters. Each request is a register write (dev+W, reg, data), sent as
// three engine byte commands, retried from the device byte on NACK, bounded
// per byte by a timeout, and answered with a per-requester completion pulse.
//
// Ports
//   clk, reset               : clock, synchronous active-high reset
//   req_valid/dev/reg/data   : per-requester write requests (packed lanes)
//   req_ready                : one-hot accept pulse
//   rsp_done, rsp_err        : one-hot completion pulse and status code
//   busy                     : accept through response
//   eng_start/byte/first/last: byte command to the engine
//   eng_busy/done/nack       : engine handshake
module i2c_write_sequencer
    import i2c_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int MAX_RETRY    = 2,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*7-1:0] req_dev,
    input  logic [NREQ*8-1:0] req_reg,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_done,
    output logic [1:0]        rsp_err,
    output logic              busy,
    output logic              eng_start,
    output logic [7:0]        eng_byte,
    output logic              eng_first,
    output logic              eng_last,
    input  logic              eng_busy,
    input  logic              eng_done,
    input  logic              eng_nack
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW   = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    seq_state_e      state_q;
    logic [NREQ-1:0] req_ready_q;
    logic [NREQ-1:0] rsp_done_q;
    logic [1:0]      rsp_err_q;
    logic            busy_q;
    logic            eng_start_q;
    logic [7:0]      eng_byte_q;
    logic            eng_first_q;
    logic            eng_last_q;
    logic [NREQ-1:0] gnt_oh_q;
    logic [IDXW-1:0] gnt_idx_q;
    logic [IDXW-1:0] last_grant_q;
    wr_req_t         req_q;
    logic [2:0]      retry_q;
    logic [TW-1:0]   tmr_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IDXW-1:0] arb_idx;
    logic            arb_valid;
    wr_req_t         sel_req;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req_i         (req_valid),
        .last_grant_i  (last_grant_q),
        .grant_o       (arb_gnt),
        .grant_idx_o   (arb_idx),
        .grant_valid_o (arb_valid)
    );

    // Fields of the requester the arbiter is about to grant.
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_req.dev   = req_dev[7*i +: 7];
                sel_req.regad = req_reg[8*i +: 8];
                sel_req.data  = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= '0;
            rsp_done_q   <= '0;
            rsp_err_q    <= I2C_OK;
            busy_q       <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_byte_q   <= '0;
            eng_first_q  <= 1'b0;
            eng_last_q   <= 1'b0;
            gnt_oh_q     <= '0;
            gnt_idx_q    <= '0;
            last_grant_q <= IDXW'(NREQ - 1);
            req_q        <= '0;
            retry_q      <= '0;
            tmr_q        <= '0;
        end else begin
            req_ready_q <= '0;
            rsp_done_q  <= '0;
            eng_start_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        req_ready_q <= arb_gnt;
                        gnt_oh_q    <= arb_gnt;
                        gnt_idx_q   <= arb_idx;
                        req_q       <= sel_req;
                        retry_q     <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= SEND_DEV;
                    end
                end

                SEND_DEV: begin
                    if (!eng_busy) begin
                        eng_start_q <= 1'b1;
                        eng_byte_q  <= {req_q.dev, I2C_WRITE};
                        eng_first_q <= 1'b1;
                        eng_last_q  <= 1'b0;
                        state_q     <= WAIT_DEV;
                    end
                end

                SEND_REG: begin
                    if (!eng_busy) begin
                        eng_start_q <= 1'b1;
                        eng_byte_q  <= req_q.regad;
                        eng_first_q <= 1'b0;
                        eng_last_q  <= 1'b0;
                        state_q     <= WAIT_REG;
                    end
                end

                SEND_DAT: begin
                    if (!eng_busy) begin
                        eng_start_q <= 1'b1;
                        eng_byte_q  <= req_q.data;
                        eng_first_q <= 1'b0;
                        eng_last_q  <= 1'b1;
                        state_q     <= WAIT_DAT;
                    end
                end

                WAIT_DEV, WAIT_REG, WAIT_DAT: begin
                    // eng_done is checked first so it beats a same-cycle timeout.
                    if (eng_done) begin
                        if (!eng_nack) begin
                            case (state_q)
                                WAIT_DEV: state_q <= SEND_REG;
                                WAIT_REG: state_q <= SEND_DAT;
                                default: begin
                                    rsp_done_q <= gnt_oh_q;
                                    rsp_err_q  <= I2C_OK;
                                    state_q    <= RESP;
                                end
                            endcase
                        end else if (retry_q < 3'(MAX_RETRY)) begin
                            // Engine has already sent STOP; restart from the address.
                            retry_q <= retry_q + 3'd1;
                            state_q <= SEND_DEV;
                        end else begin
                            rsp_done_q <= gnt_oh_q;
                            rsp_err_q  <= (state_q == WAIT_DEV) ? I2C_NACK_ADDR
                                                                : I2C_NACK_DATA;
                            state_q    <= RESP;
                        end
                    end else if (!eng_start_q && tmr_q == TW'(TIMEOUT_CLKS - 1)) begin
                        rsp_done_q <= gnt_oh_q;
                        rsp_err_q  <= I2C_TIMEOUT;
                        state_q    <= RESP;
                    end else if (eng_start_q) begin
                        // Counter restarts in the cycle the command is on the wire.
                        tmr_q <= '0;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end

                RESP: begin
                    last_grant_q <= gnt_idx_q;
                    rsp_err_q    <= I2C_OK;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_done  = rsp_done_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign eng_start = eng_start_q;
    assign eng_byte  = eng_byte_q;
    assign eng_first = eng_first_q;
    assign eng_last  = eng_last_q;

endmodule
